// File: rtl/branch_resolve_queue.sv
// Resolved-branch buffer between the branch FU and the branch stack: computes mispredict and
// redirect PC at capture, queues results in order, and drops entries killed by older mispredicts.
module branch_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 3,
  parameter int unsigned PC_W  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fu_valid,
  input  logic [TAG_W-1:0]      fu_tag,
  input  logic                  fu_taken,
  input  logic                  fu_pred_taken,
  input  logic [PC_W-1:0]       fu_pc,
  input  logic [PC_W-1:0]       fu_target,
  output logic                  fu_stall,
  input  logic [2**TAG_W-1:0]   kill_mask,
  input  logic                  squash_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [TAG_W-1:0]      res_tag,
  output logic                  res_mispredict,
  output logic [PC_W-1:0]       res_redirect_pc,
  output logic [31:0]           mispred_cnt
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] misp_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [PC_W-1:0]  rpc_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic [31:0]      mispred_cnt_q, mispred_cnt_d;

  logic not_empty, enq, deq, hs;

  assign not_empty = (count_q != '0);
  assign fu_stall  = (count_q == CntW'(DEPTH));
  assign res_valid = not_empty && v_q[rd_ptr_q];
  assign enq       = fu_valid && !fu_stall && !squash_in && !kill_mask[fu_tag];
  assign hs        = res_valid && res_ready;
  // A dead head leaves without a handshake, one per cycle.
  assign deq       = not_empty && (!v_q[rd_ptr_q] || res_ready);

  assign res_tag         = res_valid ? tag_q[rd_ptr_q] : '0;
  assign res_mispredict  = res_valid ? misp_q[rd_ptr_q] : 1'b0;
  assign res_redirect_pc = res_valid ? rpc_q[rd_ptr_q] : '0;
  assign mispred_cnt     = mispred_cnt_q;

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_mask[tag_q[i]]) v_d[i] = 1'b0;
    end
    if (deq) v_d[rd_ptr_q] = 1'b0;
    // Incoming tag is never in kill_mask when enq is set, so this cannot revive a killed slot.
    if (enq) v_d[wr_ptr_q] = 1'b1;
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (hs && misp_q[rd_ptr_q] && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      v_q           <= '0;
      mispred_cnt_q <= '0;
    end else if (squash_in) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      v_q      <= '0;
    end else begin
      v_q           <= v_d;
      mispred_cnt_q <= mispred_cnt_d;
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({enq, deq})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload needs no reset; it is only visible behind a set valid bit.
  always_ff @(posedge clock) begin
    if (enq) begin
      tag_q[wr_ptr_q]  <= fu_tag;
      misp_q[wr_ptr_q] <= fu_taken ^ fu_pred_taken;
      rpc_q[wr_ptr_q]  <= fu_taken ? fu_target : fu_pc + PC_W'(4);
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed bench for branch_resolve_queue with an in-order scoreboard of expected head results.
module tb_branch_resolve_queue;

  typedef struct {
    logic [2:0]  tag;
    logic        misp;
    logic [31:0] rpc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        fu_valid;
  logic [2:0]  fu_tag;
  logic        fu_taken;
  logic        fu_pred_taken;
  logic [31:0] fu_pc;
  logic [31:0] fu_target;
  logic        fu_stall;
  logic [7:0]  kill_mask;
  logic        squash_in;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_tag;
  logic        res_mispredict;
  logic [31:0] res_redirect_pc;
  logic [31:0] mispred_cnt;

  exp_t        sb[$];
  logic [31:0] exp_cnt;
  int          total = 0;
  int          bad = 0;

  branch_resolve_queue #(.DEPTH(4), .TAG_W(3), .PC_W(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .fu_valid        (fu_valid),
    .fu_tag          (fu_tag),
    .fu_taken        (fu_taken),
    .fu_pred_taken   (fu_pred_taken),
    .fu_pc           (fu_pc),
    .fu_target       (fu_target),
    .fu_stall        (fu_stall),
    .kill_mask       (kill_mask),
    .squash_in       (squash_in),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_tag         (res_tag),
    .res_mispredict  (res_mispredict),
    .res_redirect_pc (res_redirect_pc),
    .mispred_cnt     (mispred_cnt)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Presents one FU result for a cycle; push=1 when it is expected to be delivered later.
  task automatic drive(input logic [2:0] tag, input logic taken, input logic pred,
                       input logic [31:0] pc, input logic [31:0] target, input bit push);
    exp_t e;
    fu_valid      = 1'b1;
    fu_tag        = tag;
    fu_taken      = taken;
    fu_pred_taken = pred;
    fu_pc         = pc;
    fu_target     = target;
    if (push) begin
      e.tag  = tag;
      e.misp = taken ^ pred;
      e.rpc  = taken ? target : pc + 32'd4;
      sb.push_back(e);
    end
    tick();
    fu_valid = 1'b0;
  endtask

  // Accepts the head for one cycle and compares it with the oldest scoreboard entry.
  task automatic pop_check(input string name);
    exp_t e;
    res_ready = 1'b1;
    check({name, ".valid"}, 64'(res_valid), 64'(1));
    check({name, ".sb"}, 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({name, ".tag"}, 64'(res_tag), 64'(e.tag));
      check({name, ".misp"}, 64'(res_mispredict), 64'(e.misp));
      check({name, ".rpc"}, 64'(res_redirect_pc), 64'(e.rpc));
      if (e.misp && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    end
    tick();
    res_ready = 1'b0;
    check({name, ".cnt"}, 64'(mispred_cnt), 64'(exp_cnt));
  endtask

  task automatic check_idle(input string name);
    check({name, ".valid"}, 64'(res_valid), 64'(0));
    check({name, ".stall"}, 64'(fu_stall), 64'(0));
    check({name, ".tag"}, 64'(res_tag), 64'(0));
    check({name, ".misp"}, 64'(res_mispredict), 64'(0));
    check({name, ".rpc"}, 64'(res_redirect_pc), 64'(0));
    check({name, ".cnt"}, 64'(mispred_cnt), 64'(exp_cnt));
  endtask

  initial begin
    reset = 1'b1; fu_valid = 1'b0; fu_tag = '0; fu_taken = 1'b0; fu_pred_taken = 1'b0;
    fu_pc = '0; fu_target = '0; kill_mask = '0; squash_in = 1'b0; res_ready = 1'b0;
    exp_cnt = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");

    // Basic taken mispredict.
    drive(3'd2, 1'b1, 1'b0, 32'h100, 32'h140, 1'b1);
    check("basic.valid", 64'(res_valid), 64'(1));
    check("basic.rpc_const", 64'(res_redirect_pc), 64'h140);
    check("basic.misp_const", 64'(res_mispredict), 64'(1));
    pop_check("basic");
    check("basic.cnt_const", 64'(mispred_cnt), 64'(1));
    check("basic.empty", 64'(res_valid), 64'(0));

    // Correct not-taken with PC wrap.
    drive(3'd4, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h200, 1'b1);
    check("wrap.rpc_const", 64'(res_redirect_pc), 64'h0);
    pop_check("wrap");

    // Fill to DEPTH, then an extra result must be dropped.
    for (int i = 0; i < 4; i++) begin
      drive(3'(i), i[0], 1'b0, 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16), 1'b1);
    end
    check("full.stall", 64'(fu_stall), 64'(1));
    drive(3'd4, 1'b1, 1'b1, 32'h3000, 32'h3100, 1'b0);
    check("full.stall_hold", 64'(fu_stall), 64'(1));
    for (int i = 0; i < 4; i++) pop_check($sformatf("drain%0d", i));
    check("full.unstall", 64'(fu_stall), 64'(0));
    check("full.dropped5", 64'(res_valid), 64'(0));

    // Kill a middle entry; it is skipped with one dead cycle.
    drive(3'd1, 1'b0, 1'b1, 32'h400, 32'h480, 1'b1);
    drive(3'd3, 1'b1, 1'b0, 32'h500, 32'h580, 1'b0);
    drive(3'd5, 1'b1, 1'b1, 32'h600, 32'h680, 1'b1);
    kill_mask = 8'b0000_1000;
    tick();
    kill_mask = '0;
    check("kill.head_alive", 64'(res_valid), 64'(1));
    pop_check("kill.t1");
    res_ready = 1'b1;
    check("kill.skip", 64'(res_valid), 64'(0));
    tick();
    pop_check("kill.t5");
    check("kill.empty", 64'(res_valid), 64'(0));
    kill_mask = 8'h40;
    drive(3'd6, 1'b1, 1'b0, 32'h700, 32'h780, 1'b0);
    kill_mask = '0;
    check("kill.incoming", 64'(res_valid), 64'(0));

    // Squash with simultaneous enqueue and handshake.
    drive(3'd0, 1'b1, 1'b0, 32'h800, 32'h880, 1'b1);
    drive(3'd1, 1'b1, 1'b0, 32'h900, 32'h980, 1'b1);
    squash_in = 1'b1; res_ready = 1'b1;
    drive(3'd7, 1'b1, 1'b0, 32'hA00, 32'hA80, 1'b0);
    squash_in = 1'b0; res_ready = 1'b0;
    sb.delete();
    check_idle("squash");
    drive(3'd2, 1'b0, 1'b1, 32'hB00, 32'hB80, 1'b1);
    pop_check("post_squash");

    // Counter saturation.
    force dut.mispred_cnt_q = 32'hFFFF_FFFE;
    tick();
    release dut.mispred_cnt_q;
    exp_cnt = 32'hFFFF_FFFE;
    check("sat.preload", 64'(mispred_cnt), 64'(exp_cnt));
    for (int i = 0; i < 3; i++) drive(3'(i), 1'b0, 1'b1, 32'hC00, 32'hC80, 1'b1);
    for (int i = 0; i < 3; i++) pop_check($sformatf("sat%0d", i));
    check("sat.hold", 64'(mispred_cnt), 64'hFFFF_FFFF);

    // Reset mid-operation beats concurrent traffic.
    for (int i = 0; i < 3; i++) drive(3'(i), 1'b1, 1'b0, 32'hD00, 32'hD80, 1'b1);
    reset = 1'b1; res_ready = 1'b1; squash_in = 1'b1;
    drive(3'd5, 1'b1, 1'b0, 32'hE00, 32'hE80, 1'b0);
    reset = 1'b0; res_ready = 1'b0; squash_in = 1'b0;
    sb.delete();
    exp_cnt = 32'd0;
    check_idle("reset_mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
